// File: rtl/sobel_stream_filter_if.sv
// Pixel-stream bundle for the Sobel filter: raster pixel input with frame
// marker and per-frame config, plus the filtered result stream.
interface sobel_stream_filter_if #(
    parameter int PIX_W = 12,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] pixel_in;
    logic [1:0]       mode;
    logic [PIX_W-1:0] thresh;
    logic             out_valid;
    logic             out_sof;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;
    logic [PIX_W-1:0] pixel_out;
    logic             frame_err;

    modport master (
        output in_valid, in_sof, pixel_in, mode, thresh,
        input  out_valid, out_sof, out_x, out_y, pixel_out, frame_err
    );

    modport slave (
        input  in_valid, in_sof, pixel_in, mode, thresh,
        output out_valid, out_sof, out_x, out_y, pixel_out, frame_err
    );
endinterface

// File: rtl/sobel_stream_filter.sv
// 3x3 Sobel filter over a raster pixel stream: two line buffers feed a 3x3
// window, then Gx/Gy and abs/combine/saturate stages; 3-cycle latency.
module sobel_stream_filter #(
    parameter int PIX_W = 12,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    sobel_stream_filter_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int GW = PIX_W + 4;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [GW-1:0] SAT_MAX = {4'b0000, {PIX_W{1'b1}}};

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_reg, state_next;
    logic [XW-1:0]    x_reg;
    logic [YW-1:0]    y_reg;
    logic [1:0]       mode_reg;
    logic [PIX_W-1:0] thresh_reg;

    logic             accept, start, restart, last_pos;
    logic [XW-1:0]    pos_x;
    logic [YW-1:0]    pos_y;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (accept && !start && last_pos) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start    = bus.in_valid && bus.in_sof;
        accept   = bus.in_valid && (bus.in_sof || state_reg == ACTIVE);
        restart  = start && (state_reg == ACTIVE);
        pos_x    = start ? '0 : x_reg;
        pos_y    = start ? '0 : y_reg;
        last_pos = (pos_x == X_LAST) && (pos_y == Y_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            mode_reg   <= '0;
            thresh_reg <= '0;
        end else if (accept) begin
            if (last_pos) begin
                x_reg <= '0;
                y_reg <= '0;
            end else if (pos_x == X_LAST) begin
                x_reg <= '0;
                y_reg <= pos_y + YW'(1);
            end else begin
                x_reg <= pos_x + XW'(1);
                y_reg <= pos_y;
            end
            if (start) begin
                mode_reg   <= bus.mode;
                thresh_reg <= bus.thresh;
            end
        end
    end

    // Centre lags the newest pixel by one row plus one column.
    logic          c_valid, c_border;
    logic [XW-1:0] c_x;
    logic [YW-1:0] c_y;

    always_comb begin
        c_valid  = (pos_y >= YW'(2)) || ((pos_y == YW'(1)) && (pos_x != '0));
        c_x      = (pos_x == '0) ? X_LAST : pos_x - XW'(1);
        c_y      = (pos_x == '0) ? pos_y - YW'(2) : pos_y - YW'(1);
        c_border = (c_x == '0) || (c_x == X_LAST) || (c_y == '0) || (c_y == Y_LAST);
    end

    // ---------------- line buffers and window ----------------
    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] lb_mid [IMG_W];
    logic [PIX_W-1:0] win    [3][3];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mid[pos_x] <= bus.pixel_in;
            lb_top[pos_x] <= lb_mid[pos_x];
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_top[pos_x];
            win[1][2] <= lb_mid[pos_x];
            win[2][2] <= bus.pixel_in;
        end
    end

    logic             s1_valid, s1_sof, s1_border;
    logic [XW-1:0]    s1_x;
    logic [YW-1:0]    s1_y;
    logic [1:0]       s1_mode;
    logic [PIX_W-1:0] s1_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_border <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_mode   <= '0;
            s1_thresh <= '0;
        end else begin
            s1_valid <= accept && c_valid;
            if (accept) begin
                s1_sof    <= (c_x == '0) && (c_y == '0);
                s1_border <= c_border;
                s1_x      <= c_x;
                s1_y      <= c_y;
                s1_mode   <= mode_reg;
                s1_thresh <= thresh_reg;
            end
        end
    end

    // ---------------- gradients ----------------
    logic signed [GW-1:0] win_s [3][3];

    for (genvar gi = 0; gi < 9; gi++) begin : g_ext
        assign win_s[gi / 3][gi % 3] = $signed({4'b0000, win[gi / 3][gi % 3]});
    end

    logic signed [GW-1:0] gx_next, gy_next, gx_reg, gy_reg;

    always_comb begin
        gx_next = (win_s[0][0] + (win_s[0][1] <<< 1) + win_s[0][2])
                - (win_s[2][0] + (win_s[2][1] <<< 1) + win_s[2][2]);
        gy_next = (win_s[0][0] + (win_s[1][0] <<< 1) + win_s[2][0])
                - (win_s[0][2] + (win_s[1][2] <<< 1) + win_s[2][2]);
    end

    logic             s2_valid, s2_sof, s2_border;
    logic [XW-1:0]    s2_x;
    logic [YW-1:0]    s2_y;
    logic [1:0]       s2_mode;
    logic [PIX_W-1:0] s2_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_reg    <= '0;
            gy_reg    <= '0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_border <= 1'b0;
            s2_x      <= '0;
            s2_y      <= '0;
            s2_mode   <= '0;
            s2_thresh <= '0;
        end else begin
            gx_reg    <= gx_next;
            gy_reg    <= gy_next;
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_border <= s1_border;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s2_mode   <= s1_mode;
            s2_thresh <= s1_thresh;
        end
    end

    // ---------------- abs / combine / saturate ----------------
    function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
        return (v > SAT_MAX) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
    endfunction

    logic [GW-1:0]    abs_gx, abs_gy;
    logic [PIX_W-1:0] mag_sat, result_next;

    always_comb begin
        abs_gx  = gx_reg[GW-1] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
        abs_gy  = gy_reg[GW-1] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
        mag_sat = sat(abs_gx + abs_gy);
        case (s2_mode)
            2'b00:   result_next = sat(abs_gx);
            2'b01:   result_next = sat(abs_gy);
            2'b10:   result_next = mag_sat;
            default: result_next = (mag_sat >= s2_thresh) ? {PIX_W{1'b1}} : '0;
        endcase
        if (s2_border) result_next = '0;
    end

    logic             out_valid_reg, out_sof_reg, frame_err_reg;
    logic [XW-1:0]    out_x_reg;
    logic [YW-1:0]    out_y_reg;
    logic [PIX_W-1:0] pixel_out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            pixel_out_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            out_valid_reg <= s2_valid;
            out_sof_reg   <= s2_valid && s2_sof;
            out_x_reg     <= s2_x;
            out_y_reg     <= s2_y;
            pixel_out_reg <= result_next;
            frame_err_reg <= restart;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_sof   = out_sof_reg;
    assign bus.out_x     = out_x_reg;
    assign bus.out_y     = out_y_reg;
    assign bus.pixel_out = pixel_out_reg;
    assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on an 8x6 image: table of frame
// vectors with hand-derived result regions, plus restart and reset sequences.
module tb_sobel_stream_filter;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int P    = 12;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_stream_filter_if #(.PIX_W(P), .IMG_W(W), .IMG_H(H)) bus ();

    sobel_stream_filter #(.PIX_W(P), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int sof;
        int val;
        int cyc;
    } obs_t;

    obs_t obs[$];
    int   ferr[$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1)
            obs.push_back('{int'(bus.out_x), int'(bus.out_y), int'(bus.out_sof),
                            int'(bus.pixel_out), cyc});
        if (bus.frame_err === 1'b1)
            ferr.push_back(cyc);
    end

    // pat 0: flat 0x800; pat 1: rows 3-5 = 0xFFF; pat 2: cols 0-3 = 0x010
    typedef struct {
        int         pat;
        logic [1:0] mode;
        logic [11:0] thr;
        bit         gaps;
        int         cnt;
        int         x0, x1, y0, y1;
        int         val;
    } vec_t;

    vec_t vecs[7];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   acc[$];
    int   sof_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pix(input int pat, input int x, input int y);
        case (pat)
            0:       return 'h800;
            1:       return (y >= 3) ? 'hFFF : 0;
            2:       return (x <= 3) ? 'h010 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic idle(input int k);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Config is presented only on the sof pixel; later pixels carry inverted
    // config so an unlatched mode/thresh would corrupt the results.
    task automatic drive_frame(input int pat, input logic [1:0] md, input logic [11:0] thr,
                               input bit gaps, input int npix, input bit with_sof,
                               input bit track);
        for (int n = 0; n < npix; n++) begin
            if (gaps) begin
                int k;
                k = 0;
                while ($urandom_range(1) == 0 && k < 4) begin
                    bus.in_valid = 1'b0;
                    bus.in_sof   = 1'b0;
                    bus.pixel_in = 12'hABC;
                    @(posedge clk);
                    #1;
                    k++;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_sof   = with_sof && (n == 0);
            bus.pixel_in = 12'(pix(pat, n % W, n / W));
            if (n == 0) begin
                bus.mode   = md;
                bus.thresh = thr;
                sof_cyc    = cyc;
            end else begin
                bus.mode   = ~md;
                bus.thresh = ~thr;
            end
            if (track && n >= W + 1) acc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic check_results(input vec_t v, input int exp_cnt, input int o0,
                                 input int a0, input string tag);
        int m, ex, ey, ev;
        chk({tag, " count"}, obs.size() - o0, exp_cnt);
        m = 0;
        for (int i = o0; i < obs.size(); i++) begin
            if (obs[i].sof != 0) m = 0;
            ex = m % W;
            ey = m / W;
            ev = (ex >= v.x0 && ex <= v.x1 && ey >= v.y0 && ey <= v.y1) ? v.val : 0;
            chk($sformatf("%s coord/sof #%0d", tag, i - o0),
                (obs[i].x << 8) | (obs[i].y << 1) | obs[i].sof,
                (ex << 8) | (ey << 1) | ((m == 0) ? 1 : 0));
            chk($sformatf("%s value (%0d,%0d)", tag, ex, ey), obs[i].val, ev);
            if (i - o0 < acc.size() - a0)
                chk($sformatf("%s latency #%0d", tag, i - o0), obs[i].cyc - acc[a0 + i - o0], 3);
            m++;
        end
    endtask

    task automatic run_vec(input int idx);
        int o0, a0, f0;
        o0 = obs.size();
        a0 = acc.size();
        f0 = ferr.size();
        drive_frame(vecs[idx].pat, vecs[idx].mode, vecs[idx].thr, vecs[idx].gaps, NPIX, 1'b1, 1'b1);
        idle(8);
        check_results(vecs[idx], vecs[idx].cnt, o0, a0, $sformatf("vec%0d", idx));
        chk($sformatf("vec%0d frame_err", idx), ferr.size() - f0, 0);
    endtask

    initial begin
        int o0, a0, f0, nsof;

        vecs[0] = '{0, 2'b10, 12'h000, 1'b0, 39, 1, 0, 1, 0, 'h000};
        vecs[1] = '{1, 2'b00, 12'h000, 1'b0, 39, 1, 6, 2, 3, 'hFFF};
        vecs[2] = '{2, 2'b01, 12'h000, 1'b0, 39, 3, 4, 1, 4, 'h040};
        vecs[3] = '{2, 2'b11, 12'h040, 1'b0, 39, 3, 4, 1, 4, 'hFFF};
        vecs[4] = '{2, 2'b11, 12'h041, 1'b0, 39, 1, 0, 1, 0, 'h000};
        vecs[5] = '{2, 2'b10, 12'h000, 1'b0, 39, 3, 4, 1, 4, 'h040};
        vecs[6] = '{2, 2'b01, 12'h000, 1'b1, 39, 3, 4, 1, 4, 'h040};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.pixel_in = '0;
        bus.mode     = '0;
        bus.thresh   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_sof", int'(bus.out_sof), 0);
        chk("reset frame_err", int'(bus.frame_err), 0);
        chk("reset pixel_out", int'(bus.pixel_out), 0);
        chk("reset out_xy", int'({bus.out_x, bus.out_y}), 0);
        rst = 1'b0;

        // Pixels without a start-of-frame are dropped.
        o0 = obs.size();
        drive_frame(2, 2'b01, 12'h000, 1'b0, 30, 1'b0, 1'b0);
        idle(8);
        chk("no-sof out_valid count", obs.size() - o0, 0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Restart at n=20: old frame in Gx mode, new frame in Gy mode.
        o0 = obs.size();
        a0 = acc.size();
        f0 = ferr.size();
        drive_frame(2, 2'b00, 12'h000, 1'b0, 20, 1'b1, 1'b1);
        drive_frame(2, 2'b01, 12'h000, 1'b0, NPIX, 1'b1, 1'b1);
        idle(8);
        check_results(vecs[2], 11 + 39, o0, a0, "restart");
        chk("restart frame_err count", ferr.size() - f0, 1);
        if (ferr.size() > f0) chk("restart frame_err timing", ferr[f0] - sof_cyc, 1);
        nsof = 0;
        for (int i = o0; i < obs.size(); i++) nsof += obs[i].sof;
        chk("restart out_sof count", nsof, 2);

        // Reset mid-frame while results are streaming.
        drive_frame(2, 2'b01, 12'h000, 1'b0, 30, 1'b1, 1'b0);
        chk("pre-reset out_valid", int'(bus.out_valid), 1);
        chk("pre-reset out_xy", int'({bus.out_x, bus.out_y}), (2 << 3) | 2);
        #2 rst = 1'b1;
        #1;
        chk("async reset out_valid", int'(bus.out_valid), 0);
        chk("async reset out_xy", int'({bus.out_x, bus.out_y}), 0);
        chk("async reset pixel_out", int'(bus.pixel_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        o0 = obs.size();
        drive_frame(2, 2'b01, 12'h000, 1'b0, 20, 1'b0, 1'b0);
        idle(8);
        chk("post-reset no-sof count", obs.size() - o0, 0);
        run_vec(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
